mem_access_stage: RTL



---
 rtl/mem_access_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: drives data memory over a req/ready handshake with variable latency,
// stalls the front end while an access is outstanding and registers the MEM/WB bundle.
module mem_access_stage #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWritei,
  input  logic        RegWritei,
  input  logic [1:0]  WDSeli,
  input  logic [4:0]  A3i,
  input  logic [31:0] writedatai,
  input  logic [31:0] aluouti,
  input  logic [31:0] PCi,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        RegWriteo,
  output logic [1:0]  WDSelo,
  output logic [4:0]  A3o,
  output logic [31:0] aluouto,
  output logic [31:0] PCo,
  output logic [31:0] memdatao,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  wdsel;
    logic [4:0]  a3;
    logic [31:0] alu;
    logic [31:0] pc;
  } memwb_t;

  state_t      state, state_nxt;
  memwb_t      wb, wb_d;
  logic [31:0] md_d, cap;
  logic [7:0]  cnt;
  logic        abort, mem_op, is_load, aligned, timeout, stall_int;

  assign mem_op  = MemWritei | (WDSeli == 2'b01);
  assign is_load = ~MemWritei & (WDSeli == 2'b01);
  assign aligned = (aluouti[1:0] == 2'b00);
  assign timeout = ~dm_ready & (cnt == TIMEOUT - 8'd1);

  always_comb begin
    state_nxt = state;
    stall_int = 1'b0;
    case (state)
      IDLE: if (mem_op) begin
        stall_int = 1'b1;
        state_nxt = aligned ? WAIT : DONE;
      end
      WAIT: begin
        stall_int = 1'b1;
        if (dm_ready || timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign stall = stall_int & ~rst;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nxt;

  // MEM/WB next value: bubble while stalled, EX/MEM copy otherwise
  always_comb begin
    wb_d = '0;
    md_d = 32'd0;
    if (!stall_int) begin
      wb_d = '{rw: RegWritei, wdsel: WDSeli, a3: A3i, alu: aluouti, pc: PCi};
      if (state == DONE) begin
        md_d = cap;
        if (abort && is_load) wb_d.rw = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb       <= '0;
      memdatao <= 32'd0;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'd0;
      dm_wdata <= 32'd0;
      cnt      <= 8'd0;
      abort    <= 1'b0;
      cap      <= 32'd0;
      bus_err  <= 1'b0;
    end else begin
      wb       <= wb_d;
      memdatao <= md_d;
      case (state)
        IDLE: if (mem_op) begin
          if (aligned) begin
            dm_req   <= 1'b1;
            dm_we    <= MemWritei;
            dm_addr  <= aluouti;
            dm_wdata <= writedatai;
            cnt      <= 8'd0;
          end else begin
            bus_err <= 1'b1;
            abort   <= 1'b1;
            cap     <= 32'hDEADBEEF;
          end
        end
        WAIT: begin
          if (dm_ready) begin
            cap    <= MemWritei ? 32'd0 : dm_rdata;
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
          end else if (timeout) begin
            dm_req  <= 1'b0;
            bus_err <= 1'b1;
            abort   <= 1'b1;
            cap     <= 32'hDEADBEEF;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    abort <= 1'b0;
        default: ;
      endcase
    end
  end

  assign RegWriteo = wb.rw;
  assign WDSelo    = wb.wdsel;
  assign A3o       = wb.a3;
  assign aluouto   = wb.alu;
  assign PCo       = wb.pc;
endmodule
